// File: rtl/serial_frame_detector_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_detector_if
// Purpose  : Serial-in / parallel-out bundle between the serial shift stage
//            and the frame detector. ParErr exists only when
//            FRAME_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_frame_detector_if #(
    parameter int WIDTH = 8
) ();
    logic             D;
    logic             En;
    logic [WIDTH-1:0] Data;
    logic             Valid;
    logic             Sync;
    logic [7:0]       FrameCnt;
`ifdef FRAME_PARITY_EN
    logic             ParErr;
`endif

    // Upstream side: supplies bits, observes frames
    modport master (
        output D,
        output En,
        input  Data,
        input  Valid,
        input  Sync,
        input  FrameCnt
`ifdef FRAME_PARITY_EN
        ,
        input  ParErr
`endif
    );

    // Detector side
    modport slave (
        input  D,
        input  En,
        output Data,
        output Valid,
        output Sync,
        output FrameCnt
`ifdef FRAME_PARITY_EN
        ,
        output ParErr
`endif
    );
endinterface : serial_frame_detector_if
`default_nettype wire

// File: rtl/serial_frame_detector.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_detector
// Purpose  : Hunts a serial stream for a 4-bit sync pattern, deserializes the
//            following WIDTH payload bits and reports each frame with a
//            one-cycle Valid strobe and a wrapping 8-bit frame counter.
//            Optional macro FRAME_PARITY_EN adds a trailing even-parity bit
//            and a ParErr strobe.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_detector #(
    parameter logic [3:0] SYNC  = 4'b1011,
    parameter int         WIDTH = 8
) (
    input  wire logic              Clk,
    input  wire logic              Rst,
    serial_frame_detector_if.slave bus
);

    // Payload length outside 2..32 is not supported
    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
            $error("serial_frame_detector: WIDTH must be in 2..32");
        end
    endgenerate

    localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] c_st_hunt    = 2'd0;
    localparam logic [1:0] c_st_payload = 2'd1;
`ifdef FRAME_PARITY_EN
    localparam logic [1:0] c_st_parity  = 2'd2;
`endif

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic [3:0]         r_window;
    logic [2:0]         r_fill;
    logic [WIDTH-1:0]   r_shift;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_data;
    logic               r_valid;
    logic [7:0]         r_frame_cnt;
`ifdef FRAME_PARITY_EN
    logic               r_par_err;
    logic               w_par_ok;
`endif

    logic [3:0]         w_window_nxt;
    logic [2:0]         w_fill_nxt;
    logic               w_sync_hit;
    logic               w_last_bit;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic               w_sync;

    // Candidate window/fill after taking the current bit; fill saturates at 4
    // so an all-zero sync pattern cannot match the cleared window.
    assign w_window_nxt = {r_window[2:0], bus.D};
    assign w_fill_nxt   = (r_fill == 3'd4) ? 3'd4 : (r_fill + 3'd1);
    assign w_sync_hit   = (w_window_nxt == SYNC) && (w_fill_nxt == 3'd4);
    assign w_last_bit   = (r_count == c_last_bit);
    assign w_shift_nxt  = {r_shift[WIDTH-2:0], bus.D};
`ifdef FRAME_PARITY_EN
    // Even parity: payload plus parity bit must hold an even number of ones
    assign w_par_ok     = ~(^{r_shift, bus.D});
`endif

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= c_st_hunt;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: only bit-strobe edges advance the machine
    always_comb begin
        w_state_nxt = r_state;
        if (bus.En) begin
            case (r_state)
                c_st_hunt: begin
                    if (w_sync_hit) begin
                        w_state_nxt = c_st_payload;
                    end
                end
                c_st_payload: begin
                    if (w_last_bit) begin
`ifdef FRAME_PARITY_EN
                        w_state_nxt = c_st_parity;
`else
                        w_state_nxt = c_st_hunt;
`endif
                    end
                end
`ifdef FRAME_PARITY_EN
                c_st_parity: begin
                    w_state_nxt = c_st_hunt;
                end
`endif
                default: begin
                    w_state_nxt = c_st_hunt;
                end
            endcase
        end
    end

    // Output decode: Sync marks every post-sync state
    always_comb begin
        w_sync = 1'b0;
        case (r_state)
            c_st_payload: w_sync = 1'b1;
`ifdef FRAME_PARITY_EN
            c_st_parity:  w_sync = 1'b1;
`endif
            default:      w_sync = 1'b0;
        endcase
    end

    // Datapath: sync window, payload shifter, result registers and strobes
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_window    <= 4'd0;
            r_fill      <= 3'd0;
            r_shift     <= '0;
            r_count     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_cnt <= 8'd0;
`ifdef FRAME_PARITY_EN
            r_par_err   <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
`ifdef FRAME_PARITY_EN
            r_par_err <= 1'b0;
`endif
            if (bus.En) begin
                case (r_state)
                    c_st_hunt: begin
                        r_window <= w_window_nxt;
                        r_fill   <= w_fill_nxt;
                        if (w_sync_hit) begin
                            r_count <= '0;
                        end
                    end
                    c_st_payload: begin
                        // Exactly WIDTH bits are shifted per frame, so stale
                        // contents from a previous frame are fully flushed.
                        r_shift <= w_shift_nxt;
                        r_count <= r_count + 1'b1;
                        if (w_last_bit) begin
`ifndef FRAME_PARITY_EN
                            r_data      <= w_shift_nxt;
                            r_valid     <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + 8'd1;
`endif
                            // Hunting restarts from an empty window
                            r_window <= 4'd0;
                            r_fill   <= 3'd0;
                        end
                    end
`ifdef FRAME_PARITY_EN
                    c_st_parity: begin
                        if (w_par_ok) begin
                            r_data      <= r_shift;
                            r_valid     <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end else begin
                            r_par_err <= 1'b1;
                        end
                        r_window <= 4'd0;
                        r_fill   <= 3'd0;
                    end
`endif
                    default: begin
                        r_window <= 4'd0;
                        r_fill   <= 3'd0;
                    end
                endcase
            end
        end
    end

    assign bus.Data     = r_data;
    assign bus.Valid    = r_valid;
    assign bus.Sync     = w_sync;
    assign bus.FrameCnt = r_frame_cnt;
`ifdef FRAME_PARITY_EN
    assign bus.ParErr   = r_par_err;
`endif

endmodule : serial_frame_detector
`default_nettype wire
